// File: rtl/op_alu_seq.sv
// Self-sequencing integer ALU instruction unit: decodes OP-IMM/OP/OP-IMM-32/OP-32 from the held IR
// and steps the datapath through operand load, execute and next-instruction fetch.
module op_alu_seq #(
    parameter int XLEN   = 64,
    parameter int EN_REG = 1,
    parameter int LANE   = 16,
    localparam int RMW   = XLEN / LANE
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           go_i,
    input  logic [31:0]    ir_i,
    input  logic           trap_i,
    input  logic           ack_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           illegal_o,
    output logic           defined_o,
    output logic           ra_ir1_o,
    output logic           ra_ir2_o,
    output logic           ra_ird_o,
    output logic           alua_rf_o,
    output logic           alub_rf_o,
    output logic           alub_imm6i_o,
    output logic           alub_imm12_o,
    output logic           rf_alu_o,
    output logic [RMW-1:0] rmask_o,
    output logic [9:0]     alu_op_o,
    output logic           istb_o,
    output logic           ir_dat_irl_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LDB   = 3'd1,
        S_LDA   = 3'd2,
        S_EXE   = 3'd3,
        S_FETCH = 3'd4
    } state_t;

    // alu_op_o bit positions
    localparam int B_CFLAG = 9;
    localparam int B_SUM   = 8;
    localparam int B_AND   = 7;
    localparam int B_XOR   = 6;
    localparam int B_INVB  = 5;
    localparam int B_LSH   = 4;
    localparam int B_RSH   = 3;
    localparam int B_LTU   = 2;
    localparam int B_LTS   = 1;
    localparam int B_SX32  = 0;

    state_t state_q;
    state_t state_d;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic       is_opimm;
    logic       is_op;
    logic       is_opimm32;
    logic       is_op32;
    logic       imm_form;
    logic       w_form;
    logic       shift_f3;
    logic       shamt_ok;
    logic       funct7_ok;
    logic [9:0] alu_op_dec;
    logic       unused_ir;

    assign opc        = ir_i[6:0];
    assign f3         = ir_i[14:12];
    assign f7         = ir_i[31:25];
    assign rd         = ir_i[11:7];
    assign unused_ir  = ^ir_i[24:15];

    assign is_opimm   = (opc == 7'b0010011);
    assign is_op      = (opc == 7'b0110011) && (EN_REG != 0);
    assign is_opimm32 = (opc == 7'b0011011) && (XLEN == 64);
    assign is_op32    = (opc == 7'b0111011) && (XLEN == 64) && (EN_REG != 0);
    assign imm_form   = is_opimm | is_opimm32;
    assign w_form     = is_opimm32 | is_op32;
    assign shift_f3   = (f3 == 3'b001) || (f3 == 3'b101);

    // shamt[5] only exists for 64-bit shifts on a 64-bit datapath
    assign shamt_ok   = ((ir_i[31:26] == 6'b000000) ||
                         ((ir_i[31:26] == 6'b010000) && (f3 == 3'b101))) &&
                        !(ir_i[25] && ((XLEN == 32) || w_form));
    assign funct7_ok  = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));

    always_comb begin
        defined_o = 1'b0;
        if (imm_form) begin
            defined_o = !shift_f3 || shamt_ok;
        end else if (is_op || is_op32) begin
            defined_o = funct7_ok;
        end
    end

    // IR[30] selects SUB/SRA; defined encodings only set it for those forms
    always_comb begin
        alu_op_dec = 10'd0;
        case (f3)
            3'b000: begin
                alu_op_dec[B_SUM] = 1'b1;
                if (!imm_form && ir_i[30]) begin
                    alu_op_dec[B_CFLAG] = 1'b1;
                    alu_op_dec[B_INVB]  = 1'b1;
                end
            end
            3'b001: alu_op_dec[B_LSH] = 1'b1;
            3'b010: begin
                alu_op_dec[B_CFLAG] = 1'b1;
                alu_op_dec[B_INVB]  = 1'b1;
                alu_op_dec[B_LTS]   = 1'b1;
            end
            3'b011: begin
                alu_op_dec[B_CFLAG] = 1'b1;
                alu_op_dec[B_INVB]  = 1'b1;
                alu_op_dec[B_LTU]   = 1'b1;
            end
            3'b100: alu_op_dec[B_XOR] = 1'b1;
            3'b101: begin
                alu_op_dec[B_RSH]   = 1'b1;
                alu_op_dec[B_CFLAG] = ir_i[30];
            end
            3'b110: begin
                alu_op_dec[B_AND] = 1'b1;
                alu_op_dec[B_XOR] = 1'b1;
            end
            default: alu_op_dec[B_AND] = 1'b1;
        endcase
        alu_op_dec[B_SX32] = w_form;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_i && defined_o) state_d = S_LDB;
            S_LDB:   state_d = S_LDA;
            S_LDA:   state_d = S_EXE;
            S_EXE:   state_d = S_FETCH;
            S_FETCH: if (ack_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (trap_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        busy_o       = (state_q != S_IDLE);
        done_o       = 1'b0;
        illegal_o    = 1'b0;
        ra_ir1_o     = 1'b0;
        ra_ir2_o     = 1'b0;
        ra_ird_o     = 1'b0;
        alua_rf_o    = 1'b0;
        alub_rf_o    = 1'b0;
        alub_imm6i_o = 1'b0;
        alub_imm12_o = 1'b0;
        rf_alu_o     = 1'b0;
        rmask_o      = '0;
        alu_op_o     = 10'd0;
        istb_o       = 1'b0;
        ir_dat_irl_o = 1'b0;
        case (state_q)
            S_IDLE: illegal_o = go_i && !defined_o;
            S_LDB: begin
                if (imm_form) begin
                    alub_imm6i_o = shift_f3;
                    alub_imm12_o = !shift_f3;
                end else begin
                    ra_ir2_o = 1'b1;
                end
            end
            S_LDA: begin
                ra_ir1_o  = 1'b1;
                alub_rf_o = !imm_form;
            end
            S_EXE: begin
                alua_rf_o = 1'b1;
                ra_ird_o  = 1'b1;
                alu_op_o  = alu_op_dec;
                // a trapped instruction must not reach the register file
                rf_alu_o  = !trap_i;
                rmask_o   = ((rd != 5'd0) && !trap_i) ? '1 : '0;
            end
            S_FETCH: begin
                istb_o       = 1'b1;
                ir_dat_irl_o = 1'b1;
                done_o       = ack_i && !trap_i;
            end
            default: ;
        endcase
    end

endmodule
